// File: rtl/ps2_move_decoder.sv
// PS/2 keyboard front end: synchronises and filters the pins, deframes 11-bit frames and turns
// arrow/WASD make codes into one move pulse per physical key press.
module ps2_move_decoder #(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 200000
) (
  input  logic       clk_100mhz,
  input  logic       RSTN,
  input  logic       PS2_clk,
  input  logic       PS2_data,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [3:0] key_held
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRecv = 1'b1;

  logic clk_meta_q, clk_sync_q, data_meta_q, data_sync_q;
  logic clk_filt_q, clk_filt_prev_q;
  logic [FW-1:0] filt_cnt_q;
  logic strobe;

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      clk_meta_q      <= 1'b1;
      clk_sync_q      <= 1'b1;
      data_meta_q     <= 1'b1;
      data_sync_q     <= 1'b1;
      clk_filt_q      <= 1'b1;
      clk_filt_prev_q <= 1'b1;
      filt_cnt_q      <= '0;
    end else begin
      clk_meta_q      <= PS2_clk;
      clk_sync_q      <= clk_meta_q;
      data_meta_q     <= PS2_data;
      data_sync_q     <= data_meta_q;
      clk_filt_prev_q <= clk_filt_q;
      // Filtered clock only follows after FILTER_LEN consecutive disagreeing samples
      if (clk_sync_q != clk_filt_q) begin
        if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
          clk_filt_q <= ~clk_filt_q;
          filt_cnt_q <= '0;
        end else begin
          filt_cnt_q <= filt_cnt_q + 1'b1;
        end
      end else begin
        filt_cnt_q <= '0;
      end
    end
  end

  assign strobe = clk_filt_prev_q & ~clk_filt_q;

  logic [0:0]    state_q, state_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [8:0]    shift_q, shift_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    scan_code_q, scan_code_d;
  logic          code_valid_q, code_valid_d;
  logic          frame_err_q, frame_err_d;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tcnt_d       = '0;
    scan_code_d  = scan_code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (strobe && !data_sync_q) begin
          state_d   = StRecv;
          bit_cnt_d = 4'd1;
        end
      end
      StRecv: begin
        if (strobe) begin
          if (bit_cnt_q == 4'd10) begin
            state_d = StIdle;
            // shift_q holds {parity, data[7:0]}; current sample is the stop bit
            if ((^shift_q) && data_sync_q) begin
              code_valid_d = 1'b1;
              scan_code_d  = shift_q[7:0];
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            shift_d   = {data_sync_q, shift_q[8:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          state_d     = StIdle;
          frame_err_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tcnt_q       <= '0;
      scan_code_q  <= '0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tcnt_q       <= tcnt_d;
      scan_code_q  <= scan_code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  logic       ext_q, brk_q, move_valid_q;
  logic [1:0] move_dir_q;
  logic [3:0] held_q;
  logic       map_hit;
  logic [1:0] map_dir;

  always_comb begin
    map_hit = 1'b1;
    map_dir = 2'd0;
    if (ext_q) begin
      case (scan_code_q)
        8'h75:   map_dir = 2'd0;
        8'h72:   map_dir = 2'd1;
        8'h6B:   map_dir = 2'd2;
        8'h74:   map_dir = 2'd3;
        default: map_hit = 1'b0;
      endcase
    end else begin
      case (scan_code_q)
        8'h1D:   map_dir = 2'd0;
        8'h1B:   map_dir = 2'd1;
        8'h1C:   map_dir = 2'd2;
        8'h23:   map_dir = 2'd3;
        default: map_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_100mhz or negedge RSTN) begin
    if (!RSTN) begin
      ext_q        <= 1'b0;
      brk_q        <= 1'b0;
      held_q       <= '0;
      move_valid_q <= 1'b0;
      move_dir_q   <= '0;
    end else begin
      move_valid_q <= 1'b0;
      if (frame_err_q) begin
        ext_q <= 1'b0;
        brk_q <= 1'b0;
      end else if (code_valid_q) begin
        if (scan_code_q == 8'hE0) begin
          ext_q <= 1'b1;
        end else if (scan_code_q == 8'hF0) begin
          brk_q <= 1'b1;
        end else begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
          if (map_hit) begin
            if (brk_q) begin
              held_q[map_dir] <= 1'b0;
            end else if (!held_q[map_dir]) begin
              // Held bit suppresses typematic repeats until the break arrives
              move_valid_q    <= 1'b1;
              move_dir_q      <= map_dir;
              held_q[map_dir] <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign move_valid = move_valid_q;
  assign move_dir   = move_dir_q;
  assign scan_code  = scan_code_q;
  assign code_valid = code_valid_q;
  assign frame_err  = frame_err_q;
  assign key_held   = held_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Scoreboard bench for ps2_move_decoder: expected codes/moves/errors are queued as frames are
// driven and checked by a monitor when the DUT pulses its outputs.
module tb_ps2_move_decoder;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 1000;
  localparam int unsigned HALF = 20;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic       move_valid, code_valid, frame_err;
  logic [1:0] move_dir;
  logic [7:0] scan_code;
  logic [3:0] key_held;

  ps2_move_decoder #(
    .FILTER_LEN (FILT),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_100mhz(clk),
    .RSTN      (rstn),
    .PS2_clk   (ps2c),
    .PS2_data  (ps2d),
    .move_valid(move_valid),
    .move_dir  (move_dir),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .frame_err (frame_err),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cv_cyc = -10;
  int last_err_cyc = 0;
  int err_pending = 0;
  logic [7:0] cv_q[$];
  logic [1:0] mv_q[$];
  logic [7:0] exp_sc;
  logic [1:0] exp_dir;

  always @(posedge clk) cyc++;

  // Monitor: every DUT pulse must match the head of the matching expectation queue
  always @(negedge clk) begin
    if (rstn) begin
      if (code_valid) begin
        tests++;
        if (cv_q.size() == 0) begin
          fails++;
          $display("FAIL code_valid_unexpected: scan_code=%h, nothing expected", scan_code);
        end else begin
          exp_sc = cv_q.pop_front();
          if (scan_code !== exp_sc) begin
            fails++;
            $display("FAIL scan_code: got %h expected %h", scan_code, exp_sc);
          end
        end
        last_cv_cyc = cyc;
      end
      if (move_valid) begin
        tests++;
        if (cyc != last_cv_cyc + 1) begin
          fails++;
          $display("FAIL move_latency: move_valid %0d cycles after code_valid, expected 1",
                   cyc - last_cv_cyc);
        end
        tests++;
        if (mv_q.size() == 0) begin
          fails++;
          $display("FAIL move_valid_unexpected: move_dir=%0d, nothing expected", move_dir);
        end else begin
          exp_dir = mv_q.pop_front();
          if (move_dir !== exp_dir) begin
            fails++;
            $display("FAIL move_dir: got %0d expected %0d", move_dir, exp_dir);
          end
        end
      end
      if (frame_err) begin
        tests++;
        if (err_pending == 0) begin
          fails++;
          $display("FAIL frame_err_unexpected: pulse at cycle %0d", cyc);
        end else begin
          err_pending--;
        end
        last_err_cyc = cyc;
      end
    end
  end

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] code, input logic bad_par);
    logic [10:0] fr;
    fr = {1'b1, ~(^code) ^ bad_par, code, 1'b0};
    if (bad_par) err_pending++;
    else cv_q.push_back(code);
    for (int i = 0; i < 11; i++) ps2_bit(fr[i]);
    repeat (2 * HALF) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({move_valid, move_dir, scan_code, code_valid, frame_err, key_held} !== 17'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {move_valid, move_dir, scan_code, code_valid, frame_err, key_held});
    end
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    // Start bit plus four data bits of 1D, then a one-cycle reset
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    mv_q.push_back(2'd0);
    send_byte(8'h1D, 1'b0);
    tests++;
    if (key_held !== 4'b0001 || mv_q.size() != 0 || cv_q.size() != 0) begin
      fails++;
      $display("FAIL reset_midframe: key_held=%b queues=%0d/%0d expected 0001 0/0",
               key_held, mv_q.size(), cv_q.size());
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    tests++;
    if (key_held !== 4'b0000) begin
      fails++;
      $display("FAIL reset_release: key_held=%b expected 0000", key_held);
    end
  endtask

  task automatic test_extended;
    mv_q.push_back(2'd2);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    tests++;
    if (key_held !== 4'b0100 || mv_q.size() != 0) begin
      fails++;
      $display("FAIL ext_make: key_held=%b pending_moves=%0d expected 0100 0", key_held, mv_q.size());
    end
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    tests++;
    if (key_held !== 4'b0000) begin
      fails++;
      $display("FAIL ext_break: key_held=%b expected 0000", key_held);
    end
  endtask

  task automatic test_typematic;
    mv_q.push_back(2'd3);
    for (int i = 0; i < 3; i++) send_byte(8'h23, 1'b0);
    tests++;
    if (key_held !== 4'b1000 || mv_q.size() != 0) begin
      fails++;
      $display("FAIL typematic: key_held=%b pending_moves=%0d expected 1000 0", key_held, mv_q.size());
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
    tests++;
    if (key_held !== 4'b0000) begin
      fails++;
      $display("FAIL typematic_release: key_held=%b expected 0000", key_held);
    end
    mv_q.push_back(2'd3);
    send_byte(8'h23, 1'b0);
    tests++;
    if (key_held !== 4'b1000 || mv_q.size() != 0) begin
      fails++;
      $display("FAIL typematic_remake: key_held=%b pending_moves=%0d expected 1000 0",
               key_held, mv_q.size());
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h23, 1'b0);
  endtask

  task automatic test_parity;
    send_byte(8'h1B, 1'b1);
    tests++;
    if (scan_code !== 8'h23 || err_pending != 0 || key_held !== 4'b0000) begin
      fails++;
      $display("FAIL parity_err: scan_code=%h err_pending=%0d key_held=%b expected 23 0 0000",
               scan_code, err_pending, key_held);
    end
    mv_q.push_back(2'd1);
    send_byte(8'h1B, 1'b0);
    tests++;
    if (key_held !== 4'b0010 || move_dir !== 2'd1 || mv_q.size() != 0) begin
      fails++;
      $display("FAIL parity_recover: key_held=%b move_dir=%0d expected 0010 1", key_held, move_dir);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1B, 1'b0);
  endtask

  task automatic test_timeout;
    int t0;
    send_byte(8'hE0, 1'b0);
    err_pending++;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    t0 = cyc;
    for (int i = 0; i < 2 * TMO && err_pending != 0; i++) @(negedge clk);
    tests++;
    if (err_pending != 0) begin
      fails++;
      $display("FAIL timeout_missing: no frame_err within %0d cycles", 2 * TMO);
      err_pending = 0;
    end else begin
      tests++;
      if (last_err_cyc - t0 < int'(TMO - HALF) || last_err_cyc - t0 > int'(TMO + HALF)) begin
        fails++;
        $display("FAIL timeout_cycle: frame_err %0d cycles after idle, expected about %0d",
                 last_err_cyc - t0, TMO);
      end
    end
    send_byte(8'h75, 1'b0);
    tests++;
    if (scan_code !== 8'h75 || key_held !== 4'b0000) begin
      fails++;
      $display("FAIL timeout_ext_clear: scan_code=%h key_held=%b expected 75 0000",
               scan_code, key_held);
    end
  endtask

  task automatic test_glitch;
    ps2d = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ps2c = 1'b0;
      repeat (3) @(negedge clk);
      ps2c = 1'b1;
      repeat (10) @(negedge clk);
    end
    ps2d = 1'b1;
    repeat (10) @(negedge clk);
    mv_q.push_back(2'd2);
    send_byte(8'h1C, 1'b0);
    tests++;
    if (key_held !== 4'b0100 || move_dir !== 2'd2 || mv_q.size() != 0 || cv_q.size() != 0) begin
      fails++;
      $display("FAIL glitch: key_held=%b move_dir=%0d expected 0100 2", key_held, move_dir);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
  endtask

  task automatic test_back_to_back;
    mv_q.push_back(2'd0);
    mv_q.push_back(2'd2);
    send_byte(8'h1D, 1'b0);
    send_byte(8'h1C, 1'b0);
    tests++;
    if (key_held !== 4'b0101 || mv_q.size() != 0) begin
      fails++;
      $display("FAIL multi_held: key_held=%b expected 0101", key_held);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    mv_q.push_back(2'd0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    tests++;
    if (key_held !== 4'b0101 || mv_q.size() != 0) begin
      fails++;
      $display("FAIL arrow_after_wasd: key_held=%b expected 0101", key_held);
    end
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1C, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    tests++;
    if (key_held !== 4'b0000 || cv_q.size() != 0 || err_pending != 0) begin
      fails++;
      $display("FAIL final_release: key_held=%b expected 0000", key_held);
    end
  endtask

  initial begin
    test_reset();
    test_extended();
    test_typematic();
    test_parity();
    test_timeout();
    test_glitch();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
